// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the MIPS-subset core.
//
// Walks the shared datapath (one memory port, one ALU, IR/MDR/A/B/ALUOut)
// through fetch, decode, execute, memory and write-back. Memory phases use a
// request/acknowledge handshake and stretch for as long as mem_ack stays low.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous active-low reset
//   RT..bne             one-hot instruction flags decoded from the current IR
//   zero                ALU zero flag (branch condition)
//   mem_ack             memory finished the current access this cycle
//   mem_read/mem_write  memory request strobes, held until mem_ack
//   i_or_d              memory address select: 0 PC, 1 ALUOut
//   ir_write            load IR/MDR from memory
//   pc_write            PC load enable, branch condition already applied
//   pc_src              00 ALU, 01 ALUOut, 10 jump target, 11 register A
//   alu_src_a           0 PC, 1 A
//   alu_src_b           00 B, 01 const 4, 10 sext imm, 11 sext imm << 2
//   alu_op              00 add, 01 sub, 10 funct, 11 and
//   reg_dst             00 rt, 01 rd, 10 r31
//   mem_to_reg          00 ALUOut, 01 MDR, 10 PC
//   reg_write           register-file write enable
//   instr_done          pulse in the last cycle of every instruction
//   illegal             pulse when decode finds no flag set
//
// state | meaning
// ------+-------------------------------------------------------------
// IF    | fetch: read mem[PC], PC <= PC+4 on ack
// ID    | decode: ALUOut <= PC + (imm << 2) for branches
// EXR   | R-type execute with funct-controlled ALU
// EXI   | immediate execute (addi add, andi and)
// MADR  | lw/sw effective address into ALUOut
// MRD   | data read at ALUOut, wait for ack
// MWB   | write MDR to rt
// MWR   | data write at ALUOut, wait for ack (last state of sw)
// RWB   | write ALUOut to rd
// IWB   | write ALUOut to rt
// BR    | compare A/B, conditional PC <= ALUOut
// JMP   | PC <= jump target
// JAL   | PC <= jump target, r31 <= PC (already PC+4)
// JR    | PC <= A

module mc_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       RT,
   input  logic       addi,
   input  logic       andi,
   input  logic       lw,
   input  logic       sw,
   input  logic       j,
   input  logic       jal,
   input  logic       jr,
   input  logic       beq,
   input  logic       bne,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       instr_done,
   output logic       illegal
);

   localparam logic [3:0] S_IF   = 4'd0;
   localparam logic [3:0] S_ID   = 4'd1;
   localparam logic [3:0] S_EXR  = 4'd2;
   localparam logic [3:0] S_EXI  = 4'd3;
   localparam logic [3:0] S_MADR = 4'd4;
   localparam logic [3:0] S_MRD  = 4'd5;
   localparam logic [3:0] S_MWB  = 4'd6;
   localparam logic [3:0] S_MWR  = 4'd7;
   localparam logic [3:0] S_RWB  = 4'd8;
   localparam logic [3:0] S_IWB  = 4'd9;
   localparam logic [3:0] S_BR   = 4'd10;
   localparam logic [3:0] S_JMP  = 4'd11;
   localparam logic [3:0] S_JAL  = 4'd12;
   localparam logic [3:0] S_JR   = 4'd13;

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic [3:0] decode_target;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IF;
      end else begin
         state <= state_nxt;
      end
   end

   // Decode dispatch. The if-chain order resolves multiple set flags.
   always_comb begin
      decode_target = S_IF;
      if (RT)        decode_target = S_EXR;
      else if (lw)   decode_target = S_MADR;
      else if (sw)   decode_target = S_MADR;
      else if (addi) decode_target = S_EXI;
      else if (andi) decode_target = S_EXI;
      else if (beq)  decode_target = S_BR;
      else if (bne)  decode_target = S_BR;
      else if (jal)  decode_target = S_JAL;
      else if (j)    decode_target = S_JMP;
      else if (jr)   decode_target = S_JR;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IF:    state_nxt = mem_ack ? S_ID : S_IF;
         S_ID:    state_nxt = decode_target;
         S_EXR:   state_nxt = S_RWB;
         S_EXI:   state_nxt = S_IWB;
         S_MADR:  state_nxt = lw ? S_MRD : S_MWR;
         S_MRD:   state_nxt = mem_ack ? S_MWB : S_MRD;
         S_MWB:   state_nxt = S_IF;
         S_MWR:   state_nxt = mem_ack ? S_IF : S_MWR;
         S_RWB:   state_nxt = S_IF;
         S_IWB:   state_nxt = S_IF;
         S_BR:    state_nxt = S_IF;
         S_JMP:   state_nxt = S_IF;
         S_JAL:   state_nxt = S_IF;
         S_JR:    state_nxt = S_IF;
         default: state_nxt = S_IF;
      endcase
   end

   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state)
         S_IF: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ack;
            pc_write  = mem_ack;
         end
         S_ID: begin
            alu_src_b = 2'b11;
            if (decode_target == S_IF) begin
               illegal    = 1'b1;
               instr_done = 1'b1;
            end
         end
         S_EXR: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_EXI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = (andi && !addi) ? 2'b11 : 2'b00;
         end
         S_MADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 2'b01;
            instr_done = 1'b1;
         end
         S_MWR: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            instr_done = mem_ack;
         end
         S_RWB: begin
            reg_write  = 1'b1;
            reg_dst    = 2'b01;
            instr_done = 1'b1;
         end
         S_IWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
         S_BR: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b01;
            pc_src     = 2'b01;
            pc_write   = (beq & zero) | (bne & ~zero);
            instr_done = 1'b1;
         end
         S_JMP: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         S_JAL: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
            instr_done = 1'b1;
         end
         S_JR: begin
            pc_src     = 2'b11;
            pc_write   = 1'b1;
            instr_done = 1'b1;
         end
         default: begin
            mem_read = 1'b0;
         end
      endcase

      // The state register already sits in IF during reset; this keeps the
      // IF strobes from reaching memory until reset is released.
      if (!rst) begin
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         i_or_d     = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_src     = 2'b00;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         alu_op     = 2'b00;
         reg_dst    = 2'b00;
         mem_to_reg = 2'b00;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

endmodule
